// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU, debug and memory signal bundle for mem_port_arbiter
//
// Groups the three sides of the arbiter:
//   cpu_*  : multicycle CPU strobes, address/data, read data back, hold
//   dbg_*  : debug/loader req/ack port
//   mem_*  : single-port synchronous memory instance
// Modport slave is the arbiter's view; modport master is the surrounding
// system (CPU, debug agent and memory).
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_hold;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_owner;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic          mem_rden;
    logic [DW-1:0] mem_q;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_hold,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata, dbg_owner,
        output mem_addr, mem_data, mem_wren, mem_rden,
        input  mem_q
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_hold,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata, dbg_owner,
        input  mem_addr, mem_data, mem_wren, mem_rden,
        output mem_q
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port data memory arbiter between multicycle CPU and debug port
//
// The CPU owns the memory by default. A debug request is granted in a cycle
// where the CPU neither reads nor writes, or over a CPU write once the
// request has waited STARVE_MAX cycles. A debug access takes ISSUE then RESP;
// during ISSUE the CPU is frozen by cpu_hold if it is strobing.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-low
//   bus.cpu_*   CPU strobes/address/data in; cpu_rdata (= mem_q), cpu_hold out
//   bus.dbg_*   debug req/we/addr/wdata in; dbg_ack, dbg_rdata, dbg_owner out
//   bus.mem_*   memory addr/data/wren/rden out; mem_q in
module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int            CW         = 4;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DBG_ISSUE = 2'd1,
        DBG_RESP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rdata_q;
    logic          starved;
    logic          grant;

    assign starved = (starve_cnt == STARVE_LIM);

    // A CPU read is never pre-empted: its data appears on mem_q next cycle
    // and a debug access in between would replace it.
    assign grant = (state == IDLE) && bus.dbg_req && !bus.cpu_rd
                   && (!bus.cpu_wr || starved);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant) state_nxt = DBG_ISSUE;
            DBG_ISSUE: state_nxt = DBG_RESP;
            DBG_RESP:  state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
        end else begin
            if (state == IDLE) begin
                if (grant || !bus.dbg_req) begin
                    starve_cnt <= '0;
                end else if (!starved) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end

            // Debug fields are only sampled on the grant edge, so the
            // requester may still be changing them while it waits.
            if (grant) begin
                lat_we    <= bus.dbg_we;
                lat_addr  <= bus.dbg_addr;
                lat_wdata <= bus.dbg_wdata;
            end

            // Captured on every response, including writes.
            if (state == DBG_RESP) begin
                rdata_q <= bus.mem_q;
            end
        end
    end

    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_data  = bus.cpu_wdata;
        bus.mem_wren  = bus.cpu_wr;
        bus.mem_rden  = bus.cpu_rd;
        bus.cpu_hold  = 1'b0;
        bus.cpu_rdata = bus.mem_q;
        bus.dbg_owner = 1'b0;
        bus.dbg_ack   = 1'b0;
        bus.dbg_rdata = rdata_q;
        case (state)
            DBG_ISSUE: begin
                bus.mem_addr  = lat_addr;
                bus.mem_data  = lat_wdata;
                bus.mem_wren  = lat_we;
                bus.mem_rden  = !lat_we;
                bus.cpu_hold  = bus.cpu_rd | bus.cpu_wr;
                bus.dbg_owner = 1'b1;
            end
            DBG_RESP: begin
                // Read data is live on mem_q this cycle; present it with the
                // ack, then hold the registered copy until the next ack.
                bus.dbg_ack   = 1'b1;
                bus.dbg_rdata = bus.mem_q;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [7:0] mem [256];

    mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

    mem_port_arbiter #(
        .AW(8),
        .DW(8),
        .STARVE_MAX(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_data;
        if (bus.mem_rden) bus.mem_q <= mem[bus.mem_addr];
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'hA0;
        mem[1] = 8'hB1;
        mem[2] = 8'hC2;
        mem[3] = 8'hD3;

        reset         = 1'b0;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = 8'h00;
        bus.cpu_wdata = 8'h00;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = 8'h00;
        bus.dbg_wdata = 8'h00;

        // Reset state
        settle();
        chk("rst_ack",    bus.dbg_ack,        0);
        chk("rst_owner",  bus.dbg_owner,      0);
        chk("rst_hold",   bus.cpu_hold,       0);
        chk("rst_rdata",  bus.dbg_rdata,      0);
        chk("rst_starve", dut.starve_cnt,     0);
        chk("rst_wren",   bus.mem_wren,       0);
        chk("rst_rden",   bus.mem_rden,       0);
        tick();
        reset = 1'b1;

        // CPU-only traffic
        tick();
        bus.cpu_wr = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'h5A;
        settle();
        chk("cpu_wr_addr",  bus.mem_addr,  16'h10);
        chk("cpu_wr_data",  bus.mem_data,  16'h5A);
        chk("cpu_wr_wren",  bus.mem_wren,  1);
        chk("cpu_wr_hold",  bus.cpu_hold,  0);
        chk("cpu_wr_owner", bus.dbg_owner, 0);
        tick();
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b1;
        settle();
        chk("cpu_rd_rden",  bus.mem_rden,  1);
        chk("cpu_rd_wren",  bus.mem_wren,  0);
        chk("cpu_rd_hold",  bus.cpu_hold,  0);
        tick();
        bus.cpu_rd = 1'b0;
        settle();
        chk("cpu_rdata",    bus.cpu_rdata, 16'h5A);
        chk("cpu_rd_owner", bus.dbg_owner, 0);

        // Debug write 0x20 <- 0xC3, idle CPU
        tick();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h20; bus.dbg_wdata = 8'hC3;
        settle();
        chk("dw_idle_owner", bus.dbg_owner, 0);
        chk("dw_idle_ack",   bus.dbg_ack,   0);
        tick();
        settle();
        chk("dw_iss_owner", bus.dbg_owner, 1);
        chk("dw_iss_wren",  bus.mem_wren,  1);
        chk("dw_iss_rden",  bus.mem_rden,  0);
        chk("dw_iss_addr",  bus.mem_addr,  16'h20);
        chk("dw_iss_data",  bus.mem_data,  16'hC3);
        chk("dw_iss_hold",  bus.cpu_hold,  0);
        chk("dw_iss_ack",   bus.dbg_ack,   0);
        tick();
        settle();
        chk("dw_resp_ack",   bus.dbg_ack,   1);
        chk("dw_resp_owner", bus.dbg_owner, 0);
        tick();
        bus.dbg_req = 1'b0;
        settle();
        chk("dw_after_ack", bus.dbg_ack, 0);

        // Debug read 0x20
        tick();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h20;
        settle();
        chk("dr_idle_ack", bus.dbg_ack, 0);
        tick();
        settle();
        chk("dr_iss_rden",  bus.mem_rden,  1);
        chk("dr_iss_owner", bus.dbg_owner, 1);
        tick();
        settle();
        chk("dr_resp_ack",   bus.dbg_ack,   1);
        chk("dr_resp_rdata", bus.dbg_rdata, 16'hC3);
        tick();
        bus.dbg_req = 1'b0;
        settle();
        chk("dr_held_ack",   bus.dbg_ack,   0);
        chk("dr_held_rdata", bus.dbg_rdata, 16'hC3);

        // Continuous CPU writes starve a debug write for STARVE_MAX cycles
        tick();
        bus.cpu_wr = 1'b1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 8'h77;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h31; bus.dbg_wdata = 8'h11;
        settle();
        chk("st_w1_owner", bus.dbg_owner, 0);
        chk("st_w1_cnt",   dut.starve_cnt, 0);
        chk("st_w1_addr",  bus.mem_addr,  16'h30);
        tick();
        settle();
        chk("st_w2_cnt",   dut.starve_cnt, 1);
        chk("st_w2_owner", bus.dbg_owner, 0);
        tick();
        settle();
        chk("st_w3_owner", bus.dbg_owner, 0);
        tick();
        settle();
        chk("st_w4_owner", bus.dbg_owner, 0);
        chk("st_w4_cnt",   dut.starve_cnt, 3);
        tick();
        settle();
        chk("st_w5_owner", bus.dbg_owner, 0);
        chk("st_w5_cnt",   dut.starve_cnt, 4);
        chk("st_w5_hold",  bus.cpu_hold,  0);
        tick();
        bus.cpu_addr = 8'h33; bus.cpu_wdata = 8'h99;
        settle();
        chk("st_iss_owner", bus.dbg_owner, 1);
        chk("st_iss_hold",  bus.cpu_hold,  1);
        chk("st_iss_addr",  bus.mem_addr,  16'h31);
        chk("st_iss_data",  bus.mem_data,  16'h11);
        chk("st_iss_wren",  bus.mem_wren,  1);
        tick();
        settle();
        chk("st_resp_hold", bus.cpu_hold,  0);
        chk("st_resp_ack",  bus.dbg_ack,   1);
        chk("st_resp_addr", bus.mem_addr,  16'h33);
        chk("st_resp_data", bus.mem_data,  16'h99);
        chk("st_resp_wren", bus.mem_wren,  1);
        tick();
        bus.dbg_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b1; bus.cpu_addr = 8'h33;
        settle();
        chk("st_rd33_owner", bus.dbg_owner, 0);
        tick();
        bus.cpu_addr = 8'h31;
        settle();
        chk("st_late_wr", bus.cpu_rdata, 16'h99);
        tick();
        bus.cpu_rd = 1'b0;
        settle();
        chk("st_dbg_wr", bus.cpu_rdata, 16'h11);

        // Debug request rises together with a CPU read
        tick();
        bus.cpu_rd = 1'b1; bus.cpu_addr = 8'h20;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h20; bus.dbg_wdata = 8'hEE;
        settle();
        chk("rc_owner", bus.dbg_owner, 0);
        chk("rc_rden",  bus.mem_rden,  1);
        chk("rc_wren",  bus.mem_wren,  0);
        tick();
        bus.cpu_rd = 1'b0;
        settle();
        chk("rc_rdata",  bus.cpu_rdata, 16'hC3);
        chk("rc_owner2", bus.dbg_owner, 0);
        tick();
        settle();
        chk("rc_iss_owner", bus.dbg_owner, 1);
        tick();
        settle();
        chk("rc_resp_ack", bus.dbg_ack, 1);
        tick();
        bus.dbg_req = 1'b0;

        // Reset pulsed during DBG_ISSUE
        tick();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h00;
        settle();
        chk("rs_idle_owner", bus.dbg_owner, 0);
        tick();
        bus.cpu_wr = 1'b1; bus.cpu_addr = 8'h50; bus.cpu_wdata = 8'h66;
        settle();
        chk("rs_iss_owner", bus.dbg_owner, 1);
        chk("rs_iss_hold",  bus.cpu_hold,  1);
        #1;
        reset = 1'b0;
        bus.cpu_wr = 1'b0;
        #1;
        chk("rs_owner",  bus.dbg_owner,  0);
        chk("rs_hold",   bus.cpu_hold,   0);
        chk("rs_ack",    bus.dbg_ack,    0);
        chk("rs_starve", dut.starve_cnt, 0);
        tick();
        settle();
        chk("rs_ack_held", bus.dbg_ack, 0);
        tick();
        reset = 1'b1; bus.dbg_req = 1'b0;
        settle();
        chk("rs_rel_ack",   bus.dbg_ack,   0);
        chk("rs_rel_owner", bus.dbg_owner, 0);

        // Back-to-back debug reads of 0x00..0x03, dbg_req held high
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == 0) ? 8'hA0 : (i == 1) ? 8'hB1 : (i == 2) ? 8'hC2 : 8'hD3;
            tick();
            bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'(i);
            settle();
            chk("bb_idle_ack", bus.dbg_ack, 0);
            tick();
            settle();
            chk("bb_iss_addr",  bus.mem_addr,  16'(i));
            chk("bb_iss_owner", bus.dbg_owner, 1);
            tick();
            settle();
            chk("bb_resp_ack",   bus.dbg_ack,   1);
            chk("bb_resp_rdata", bus.dbg_rdata, 16'(exp_d));
        end
        tick();
        bus.dbg_req = 1'b0;
        settle();
        chk("bb_held_rdata", bus.dbg_rdata, 16'hD3);
        chk("bb_end_ack",    bus.dbg_ack,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the processor's single-port synchronous data memory between the multicycle CPU (FSM-driven MemRead/MemWrite, address and write data) and a debug/loader port with a req/ack handshake. It sits between the datapath's address/data muxes and the memory instance, and freezes the CPU control FSM with a hold signal while a debug access owns the memory. The CPU has default priority. Debug gets the memory in CPU-idle cycles, and is forced through after a bounded wait.

## Interface
- AW, 8, address width
- DW, 8, data width
- STARVE_MAX, 4, cycles a pending debug request waits before CPU writes are pre-empted (1..15)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_rd, cpu_wr  in  1 each  CPU memory read/write strobes
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  read data to the CPU; equals mem_q
- cpu_hold  out  1  freezes the CPU FSM and all CPU datapath enables this cycle
- dbg_req  in  1  debug request; held high until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DW  debug read data; valid with dbg_ack and held until the next ack
- mem_addr  out  AW  memory address
- mem_data  out  DW  memory write data
- mem_wren  out  1  memory write enable
- mem_rden  out  1  memory read enable
- mem_q  in  DW  memory read data, valid one cycle after the read edge
- dbg_owner  out  1  1 while the debug port drives the memory

## Operation
- States: IDLE (CPU owns the memory), DBG_ISSUE, DBG_RESP.
- IDLE:
  - mem_addr, mem_data, mem_wren, mem_rden come combinationally from the cpu_* signals.
  - starve_cnt increments each cycle dbg_req is high, saturating at STARVE_MAX. It clears when dbg_req is low.
  - Go to DBG_ISSUE when dbg_req & !cpu_rd & (!cpu_wr | starve_cnt==STARVE_MAX).
  - CPU reads are never pre-empted, because that protects the mem_q value the CPU reads next cycle.
  - On the grant edge, latch dbg_we, dbg_addr, dbg_wdata and clear starve_cnt.
- DBG_ISSUE:
  - dbg_owner=1. Memory is driven from the latched request: mem_wren=we, mem_rden=!we.
  - cpu_hold = cpu_rd | cpu_wr. CPU strobes are not forwarded.
  - Always go to DBG_RESP.
- DBG_RESP:
  - dbg_ack=1 and dbg_rdata=mem_q. The output register captures mem_q on this edge, even for writes.
  - The memory returns to the CPU with the same muxing as IDLE, and cpu_hold=0.
  - Always go to IDLE.
- dbg_req still high in the IDLE cycle after an ack is a new request.
- Debug fields that change while a request is pending but before the grant edge are sampled at the grant edge.
- cpu_rdata = mem_q in every state. The arbiter adds no CPU latency when not holding.

## Timing
- Reset values:
  - state=IDLE, starve_cnt=0, dbg_rdata=0, dbg_ack=0, dbg_owner=0, cpu_hold=0.
  - mem_wren and mem_rden follow the cpu_* inputs, which are 0 while the CPU is in reset.
- Debug latency from the grant edge: 2 cycles. Minimum from dbg_req rising in an idle system: ack on the 3rd cycle (IDLE, ISSUE, RESP).
- Worst-case wait with continuous CPU writes: STARVE_MAX cycles, then grant.
- Continuous CPU reads can defer debug indefinitely. This is accepted because the multicycle CPU never reads on consecutive cycles without a non-read cycle.
- cpu_hold is combinational from state and the CPU strobes. It lasts at most 1 cycle per debug access.
- Simultaneous dbg_req rise and cpu_wr with starve_cnt<STARVE_MAX: the CPU wins and the count starts.
- Reset asserted mid-access: immediate return to IDLE, ack suppressed, hold released. A write issued on an earlier edge remains in memory.
- Addresses wrap naturally at 2^AW. The arbiter does no range checking.

## Test plan
- CPU-only traffic, dbg_req=0: cpu_wr addr 0x10 data 0x5A, then cpu_rd 0x10 -> mem signals mirror the CPU, cpu_rdata=0x5A next cycle, cpu_hold never 1, dbg_owner never 1.
- Idle CPU, debug write 0x20<-0xC3, then debug read 0x20 -> each ack arrives 2 cycles after its grant edge, and the second has dbg_rdata=0xC3 held after the ack.
- Continuous cpu_wr with dbg_req high, STARVE_MAX=4 -> grant after exactly 4 wait cycles, cpu_hold=1 for exactly 1 cycle, and the CPU write lands 1 cycle late with correct data.
- dbg_req rises in the same cycle as cpu_rd -> no grant that cycle, and the CPU read data is uncorrupted on the next cycle.
- Reset pulsed low during DBG_ISSUE -> state IDLE, dbg_ack never pulses, cpu_hold=0 and starve_cnt=0 immediately.
- Back-to-back debug reads of 0x00..0x03 with dbg_req held high -> 4 acks spaced 3 cycles apart, with the data matching preloaded memory.
